wide_imm_builder: RTL and testbench
===================================

WIDE_IMM_BUILDER -- requirements
Module: wide_imm_builder

Interface
REQ-001 Parameter STEP_CYCLES, default 1, SHALL set the clock cycles each halfword step occupies (legal 1..4).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-003 Reset  input  1  SHALL be an asynchronous, active-high reset.
REQ-004 ReqValid  input  1  SHALL flag a 64-bit constant build request.
REQ-005 ReqReady  output  1  SHALL flag that a request can be accepted.
REQ-006 ReqValue  input  64  SHALL carry the target constant; sampled only on acceptance.
REQ-007 RespValid  output  1  SHALL flag that RespValue/RespSteps are valid.
REQ-008 RespReady  input  1  SHALL flag that the consumer takes the response.
REQ-009 RespValue  output  64  SHALL carry the assembled constant.
REQ-010 RespSteps  output  3  SHALL carry the number of MOVZ/MOVK steps used (0..4).
REQ-011 Busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-012 The FSM SHALL have three states, IDLE, STEP and DONE; ReqReady SHALL be high only in IDLE.
REQ-013 Acceptance SHALL occur on an edge where ReqValid and ReqReady are both high: capture ReqValue, clear the accumulator and the step count, and select the first halfword to process.
REQ-014 In STEP the block SHALL drive the extender with Ctrl=3'b100 (MOVZ) and Imm26 = {3'b000, hw[1:0], ReqValue halfword hw, 5'b00000}.
REQ-015 On the last cycle of each step the extender output SHALL be ORed into the accumulator (MOVK merge), RespSteps incremented, and the next selected halfword chosen.
REQ-016 Each step SHALL last exactly STEP_CYCLES cycles, counted by a step-cycle counter that reloads at every step start.
REQ-017 With N steps and acceptance at edge k, the FSM SHALL enter DONE at edge k+N*STEP_CYCLES; if N=0, it SHALL enter DONE at edge k.
REQ-018 In DONE, RespValid SHALL be high, RespValue SHALL equal the accumulator, and both SHALL be held stable until RespReady is high.
REQ-019 DONE with RespReady high SHALL return to IDLE on that edge; a new request SHALL NOT be accepted in the same cycle.
REQ-020 ReqValid asserted outside IDLE SHALL be ignored with no state change.
REQ-021 The final RespValue SHALL always equal the captured ReqValue.

Reset
REQ-022 Reset SHALL force IDLE and clear the accumulator, step count and step-cycle counter, including mid-operation, with no response issued for the aborted request.
REQ-023 Output values during reset: ReqReady=1, RespValid=0, RespValue=0, RespSteps=0, Busy=0.

Configuration
REQ-024 With MOVK_ZERO_SKIP_EN defined, halfword selection SHALL skip zero halfwords, so N equals the number of nonzero halfwords; an all-zero request SHALL therefore take 0 steps and go straight to DONE.
REQ-025 With MOVK_ZERO_SKIP_EN undefined, all four halfwords SHALL be processed in order 0..3, so N=4 always.

Structure
REQ-026 Shared package imm_pkg SHALL hold the FSM state encoding, the MOVZ control constant 3'b100, and the step-count width.
REQ-027 The block SHALL instantiate exactly one sub-module, sign_extender, which is combinational and driven by the FSM.

Verification
REQ-028 Reset release -> ReqReady=1, RespValid=0, RespValue=0, RespSteps=0, Busy=0.
REQ-029 ReqValue=0x1234_0000_ABCD_0000 with skip enabled -> RespValid one edge after the second step edge (2 cycles after acceptance), RespValue equal to the request, RespSteps=2; with skip disabled -> RespSteps=4, RespValid after 4 cycles.
REQ-030 ReqValue=0 with skip enabled -> DONE at the acceptance edge, RespValue=0, RespSteps=0.
REQ-031 RespReady held low for 5 cycles in DONE, with ReqValid pulsed -> RespValue held stable, ReqReady=0, the pulsed request dropped; after RespReady -> IDLE, and the next request is accepted one cycle later.
REQ-032 ReqValue=0xFFFF_FFFF_FFFF_FFFF with Reset asserted during step 2 -> immediate IDLE, all outputs at reset values, no RespValid.
REQ-033 STEP_CYCLES=3 with ReqValue=0xFFFF_FFFF_FFFF_FFFF -> RespValid 12 cycles after acceptance, RespSteps=4, RespValue=0xFFFF_FFFF_FFFF_FFFF.

Source files
------------

// File: rtl/imm_pkg.sv
// Shared definitions for the wide immediate builder: FSM encoding, extender controls,
// step-count width and the halfword selection helper.
package imm_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StStep,
        StDone
    } state_e;

    localparam int unsigned StepCntW = 3;

    localparam logic [2:0] CtrlB     = 3'b000;
    localparam logic [2:0] CtrlCb    = 3'b001;
    localparam logic [2:0] CtrlImm12 = 3'b010;
    localparam logic [2:0] CtrlMovz  = 3'b100;

    // Lowest set mask bit at or above start; 3'b100 means nothing left to process.
    function automatic logic [2:0] next_sel(input logic [3:0] mask, input logic [2:0] start);
        logic [2:0] sel;
        sel = 3'b100;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= start)) begin
                sel = 3'(i);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/sign_extender.sv
// Combinational immediate extender: branch/compare-branch sign extension, imm12 zero
// extension and MOVZ halfword placement.
module sign_extender
    import imm_pkg::*;
(
    input  logic [2:0]  ctrl,
    input  logic [25:0] imm26,
    output logic [63:0] imm_ext
);

    always_comb begin
        imm_ext = '0;
        case (ctrl)
            CtrlB:     imm_ext = {{38{imm26[25]}}, imm26};
            CtrlCb:    imm_ext = {{45{imm26[23]}}, imm26[23:5]};
            CtrlImm12: imm_ext = {52'b0, imm26[21:10]};
            // imm26 = {3'b0, hw[1:0], imm16, 5'b0}
            CtrlMovz:  imm_ext = {48'b0, imm26[20:5]} << {imm26[22:21], 4'b0000};
            default:   imm_ext = '0;
        endcase
    end

endmodule

// File: rtl/wide_imm_builder.sv
// Builds a 64-bit constant one MOVZ-extended halfword per step, OR-merged into an accumulator.
// Define MOVK_ZERO_SKIP_EN to skip all-zero halfwords.
module wide_imm_builder
    import imm_pkg::*;
#(
    parameter int unsigned STEP_CYCLES = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                ReqValid,
    output logic                ReqReady,
    input  logic [63:0]         ReqValue,
    output logic                RespValid,
    input  logic                RespReady,
    output logic [63:0]         RespValue,
    output logic [StepCntW-1:0] RespSteps,
    output logic                Busy
);

    localparam logic [1:0] CycLast = 2'(STEP_CYCLES - 1);

    state_e              state_q, state_d;
    logic [63:0]         value_q, value_d;
    logic [63:0]         acc_q, acc_d;
    logic [StepCntW-1:0] steps_q, steps_d;
    logic [1:0]          hw_q, hw_d;
    logic [1:0]          cyc_q, cyc_d;
    logic [3:0]          req_mask, val_mask;
    logic [2:0]          sel;
    logic [15:0]         cur_half;
    logic [2:0]          ext_ctrl;
    logic [25:0]         ext_imm;
    logic [63:0]         ext_out;

`ifdef MOVK_ZERO_SKIP_EN
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_mask[i] = |ReqValue[16*i +: 16];
            val_mask[i] = |value_q[16*i +: 16];
        end
    end
`else
    assign req_mask = 4'hF;
    assign val_mask = 4'hF;
`endif

    assign cur_half = value_q[{hw_q, 4'b0000} +: 16];
    assign ext_ctrl = (state_q == StStep) ? CtrlMovz : CtrlB;
    assign ext_imm  = (state_q == StStep) ? {3'b000, hw_q, cur_half, 5'b00000} : '0;

    sign_extender u_ext (
        .ctrl    (ext_ctrl),
        .imm26   (ext_imm),
        .imm_ext (ext_out)
    );

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        acc_d   = acc_q;
        steps_d = steps_q;
        hw_d    = hw_q;
        cyc_d   = cyc_q;
        sel     = 3'b100;
        case (state_q)
            StIdle: begin
                if (ReqValid) begin
                    value_d = ReqValue;
                    acc_d   = '0;
                    steps_d = '0;
                    cyc_d   = '0;
                    sel     = next_sel(req_mask, 3'd0);
                    if (sel[2]) begin
                        state_d = StDone;
                    end else begin
                        hw_d    = sel[1:0];
                        state_d = StStep;
                    end
                end
            end
            StStep: begin
                if (cyc_q == CycLast) begin
                    acc_d   = acc_q | ext_out;
                    steps_d = steps_q + 3'd1;
                    cyc_d   = '0;
                    sel     = next_sel(val_mask, {1'b0, hw_q} + 3'd1);
                    if (sel[2]) begin
                        state_d = StDone;
                    end else begin
                        hw_d = sel[1:0];
                    end
                end else begin
                    cyc_d = cyc_q + 2'd1;
                end
            end
            StDone: begin
                if (RespReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= StIdle;
            value_q <= '0;
            acc_q   <= '0;
            steps_q <= '0;
            hw_q    <= '0;
            cyc_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            acc_q   <= acc_d;
            steps_q <= steps_d;
            hw_q    <= hw_d;
            cyc_q   <= cyc_d;
        end
    end

    assign ReqReady  = (state_q == StIdle);
    assign RespValid = (state_q == StDone);
    assign Busy      = (state_q != StIdle);
    assign RespValue = acc_q;
    assign RespSteps = steps_q;

endmodule

// File: tb/tb_wide_imm_builder.sv
// Scoreboard bench for wide_imm_builder: one instance with STEP_CYCLES=1, one with 3.
module tb_wide_imm_builder;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid0, ReqReady0, RespValid0, RespReady0, Busy0;
    logic [63:0] ReqValue0, RespValue0;
    logic [2:0]  RespSteps0;
    logic        ReqValid1, ReqReady1, RespValid1, RespReady1, Busy1;
    logic [63:0] ReqValue1, RespValue1;
    logic [2:0]  RespSteps1;

    typedef struct {
        logic [63:0] value;
        int          steps;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [63:0] v;
        int          ns;
        int          nn;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t cur[2];
    bit   in_resp[2];
    int   compared = 0;
    int   mismatched = 0;
    int   cycle = 0;

    wide_imm_builder #(.STEP_CYCLES(1)) dut0 (
        .CLK       (CLK),
        .Reset     (Reset),
        .ReqValid  (ReqValid0),
        .ReqReady  (ReqReady0),
        .ReqValue  (ReqValue0),
        .RespValid (RespValid0),
        .RespReady (RespReady0),
        .RespValue (RespValue0),
        .RespSteps (RespSteps0),
        .Busy      (Busy0)
    );

    wide_imm_builder #(.STEP_CYCLES(3)) dut1 (
        .CLK       (CLK),
        .Reset     (Reset),
        .ReqValid  (ReqValid1),
        .ReqReady  (ReqReady1),
        .ReqValue  (ReqValue1),
        .RespValid (RespValid1),
        .RespReady (RespReady1),
        .RespValue (RespValue1),
        .RespSteps (RespSteps1),
        .Busy      (Busy1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    function automatic int pick(input int ns, input int nn);
`ifdef MOVK_ZERO_SKIP_EN
        return ns;
`else
        return nn;
`endif
    endfunction

    task automatic monitor(input int id, input logic rv, input logic rr, input logic rq,
                           input logic [63:0] val, input logic [2:0] st);
        exp_t it;
        if (rv !== 1'b1) return;
        if (!in_resp[id]) begin
            if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_resp dut%0d: got value 0x%0h, expected no response",
                         id, val);
                return;
            end
            if (id == 0) it = q0.pop_front();
            else it = q1.pop_front();
            cur[id]     = it;
            in_resp[id] = 1'b1;
            check($sformatf("latency_dut%0d", id), 64'(cycle - it.acc), 64'(it.lat));
            check($sformatf("steps_dut%0d", id), 64'(st), 64'(it.steps));
        end
        check($sformatf("value_dut%0d", id), val, cur[id].value);
        check($sformatf("req_ready_in_done_dut%0d", id), 64'(rq), 64'd0);
        if (rr === 1'b1) in_resp[id] = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (Reset === 1'b0) begin
            monitor(0, RespValid0, RespReady0, ReqReady0, RespValue0, RespSteps0);
            monitor(1, RespValid1, RespReady1, ReqReady1, RespValue1, RespSteps1);
        end
    end

    task automatic send(input int id, input logic [63:0] v, input int n, input bit push);
        int   guard = 0;
        exp_t it;
        while (((id == 0) ? ReqReady0 : ReqReady1) !== 1'b1 && guard < 100) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        if (guard >= 100) begin
            compared++;
            mismatched++;
            $display("FAIL req_ready_timeout dut%0d: ReqReady low for 100 cycles", id);
        end
        if (id == 0) begin ReqValid0 = 1'b1; ReqValue0 = v; end
        else begin ReqValid1 = 1'b1; ReqValue1 = v; end
        @(posedge CLK);
        #1;
        it.value = v;
        it.steps = n;
        it.lat   = n * ((id == 0) ? 1 : 3);
        it.acc   = cycle;
        if (push) begin
            if (id == 0) q0.push_back(it);
            else q1.push_back(it);
        end
        // Scramble the bus so a late re-sample of ReqValue would show up
        if (id == 0) begin ReqValid0 = 1'b0; ReqValue0 = ~v; end
        else begin ReqValid1 = 1'b0; ReqValue1 = ~v; end
    endtask

    task automatic wait_done(input int id);
        int guard = 0;
        while (guard < 200 &&
               (((id == 0) ? q0.size() : q1.size()) != 0 || in_resp[id])) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        if (guard >= 200) begin
            compared++;
            mismatched++;
            $display("FAIL resp_timeout dut%0d: no response within 200 cycles", id);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        exp_t it;
        int   guard;

        vecs.push_back('{64'h1234_0000_ABCD_0000, 2, 4});
        vecs.push_back('{64'h0000_0000_0000_0000, 0, 4});
        vecs.push_back('{64'hFFFF_FFFF_FFFF_FFFF, 4, 4});
        vecs.push_back('{64'h0000_0000_0000_0001, 1, 4});
        vecs.push_back('{64'h8000_0000_0000_0000, 1, 4});
        vecs.push_back('{64'h0001_0002_0003_0004, 4, 4});
        vecs.push_back('{64'hDEAD_0000_0000_BEEF, 2, 4});

        Reset = 1'b1;
        ReqValid0 = 1'b0; ReqValue0 = '0; RespReady0 = 1'b1;
        ReqValid1 = 1'b0; ReqValue1 = '0; RespReady1 = 1'b1;
        #12;
        check("rst_req_ready", 64'(ReqReady0), 64'd1);
        check("rst_resp_valid", 64'(RespValid0), 64'd0);
        check("rst_resp_value", RespValue0, 64'd0);
        check("rst_resp_steps", 64'(RespSteps0), 64'd0);
        check("rst_busy", 64'(Busy0), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        @(posedge CLK);
        #1;
        check("rel_req_ready", 64'(ReqReady0), 64'd1);
        check("rel_resp_valid", 64'(RespValid0), 64'd0);
        check("rel_resp_value", RespValue0, 64'd0);
        check("rel_resp_steps", 64'(RespSteps0), 64'd0);
        check("rel_busy", 64'(Busy0), 64'd0);
        check("rel_busy_dut1", 64'(Busy1), 64'd0);

        foreach (vecs[i]) begin
            send(0, vecs[i].v, pick(vecs[i].ns, vecs[i].nn), 1'b1);
            wait_done(0);
        end

        // Response held with RespReady low; a request pulsed meanwhile must be dropped
        RespReady0 = 1'b0;
        send(0, 64'h0000_5555_0000_AAAA, pick(2, 4), 1'b1);
        guard = 0;
        while (RespValid0 !== 1'b1 && guard < 50) begin
            @(posedge CLK);
            #1;
            guard++;
        end
        check("hold_resp_seen", 64'(RespValid0), 64'd1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                ReqValid0 = 1'b1;
                ReqValue0 = 64'h1111_1111_1111_1111;
            end else begin
                ReqValid0 = 1'b0;
            end
            @(posedge CLK);
            #1;
        end
        check("hold_resp_valid", 64'(RespValid0), 64'd1);
        check("hold_resp_steps", 64'(RespSteps0), 64'(pick(2, 4)));
        RespReady0 = 1'b1;
        ReqValid0  = 1'b1;
        ReqValue0  = 64'h0F0F_0000_0000_0F0F;
        @(posedge CLK);
        #1;
        check("idle_after_take", 64'(ReqReady0), 64'd1);
        check("busy_after_take", 64'(Busy0), 64'd0);
        @(posedge CLK);
        #1;
        check("accept_next_cycle", 64'(Busy0), 64'd1);
        it.value = 64'h0F0F_0000_0000_0F0F;
        it.steps = pick(2, 4);
        it.lat   = it.steps;
        it.acc   = cycle;
        q0.push_back(it);
        ReqValid0 = 1'b0;
        wait_done(0);

        // Reset during the second step aborts with no response
        send(0, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b0);
        @(posedge CLK);
        #1;
        check("abort_mid_steps", 64'(RespSteps0), 64'd1);
        Reset = 1'b1;
        in_resp[0] = 1'b0;
        #1;
        check("abort_req_ready", 64'(ReqReady0), 64'd1);
        check("abort_resp_valid", 64'(RespValid0), 64'd0);
        check("abort_resp_value", RespValue0, 64'd0);
        check("abort_resp_steps", 64'(RespSteps0), 64'd0);
        check("abort_busy", 64'(Busy0), 64'd0);
        @(negedge CLK);
        Reset = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        check("abort_no_resp", 64'(RespValid0), 64'd0);
        check("abort_idle", 64'(Busy0), 64'd0);

        send(1, 64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b1);
        wait_done(1);
        send(1, 64'h1234_0000_ABCD_0000, pick(2, 4), 1'b1);
        wait_done(1);
        send(0, 64'h0000_0000_0000_0000, pick(0, 4), 1'b1);
        wait_done(0);

        repeat (3) @(posedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
